// File: rtl/phys_reg_release_queue.sv
// Staging FIFO between ROB commit and the 3-port physical-register free list.
// Optional duplicate-release filtering is enabled by defining RELEASE_DUP_CHECK_EN.
module phys_reg_release_queue #(
  parameter int unsigned FL_DEPTH = 32,
  parameter int unsigned TAG_W    = $clog2(FL_DEPTH),
  parameter int unsigned Q_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rel_valid_0,
  input  logic                     rel_valid_1,
  input  logic                     rel_valid_2,
  input  logic [TAG_W-1:0]         rel_tag_0,
  input  logic [TAG_W-1:0]         rel_tag_1,
  input  logic [TAG_W-1:0]         rel_tag_2,
  output logic                     rel_ready,
  input  logic [TAG_W:0]           fl_count,
  output logic                     fl_wr_en_0,
  output logic                     fl_wr_en_1,
  output logic                     fl_wr_en_2,
  output logic [TAG_W-1:0]         fl_wr_tag_0,
  output logic [TAG_W-1:0]         fl_wr_tag_1,
  output logic [TAG_W-1:0]         fl_wr_tag_2,
  output logic [$clog2(Q_DEPTH):0] q_count,
  output logic                     ovf_err,
  output logic                     dup_err
);

  localparam int unsigned QA_W  = $clog2(Q_DEPTH);
  localparam int unsigned PTR_W = QA_W + 1;
  localparam int unsigned FLC_W = TAG_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] q_count_q, q_count_d;
  logic [TAG_W-1:0] mem_q [Q_DEPTH];
  logic [TAG_W-1:0] mem_d [Q_DEPTH];
  logic             ovf_q, ovf_d;

  logic [2:0]       slot_valid;
  logic [TAG_W-1:0] slot_tag [3];
  logic [TAG_W-1:0] enq_tag [3];
  logic [1:0]       n_in, n_out;
  logic [FLC_W-1:0] headroom;
  logic [2:0]       wr_en_c;
  logic [TAG_W-1:0] wr_tag_c [3];

`ifdef RELEASE_DUP_CHECK_EN
  logic [FL_DEPTH-1:0] pend_q, pend_d;
  logic [FL_DEPTH-1:0] seen;
  logic                dup_q, dup_d;
`endif

  assign slot_valid  = {rel_valid_2, rel_valid_1, rel_valid_0};
  assign slot_tag[0] = rel_tag_0;
  assign slot_tag[1] = rel_tag_1;
  assign slot_tag[2] = rel_tag_2;

  assign rel_ready = (q_count_q <= PTR_W'(Q_DEPTH - 3));

  // Drain: up to 3 head entries, limited by occupancy and free-list headroom
  always_comb begin
    headroom = '0;
    n_out    = 2'd3;
    wr_en_c  = '0;
    for (int k = 0; k < 3; k++) wr_tag_c[k] = '0;
    if (fl_count < FLC_W'(FL_DEPTH)) headroom = FLC_W'(FL_DEPTH) - fl_count;
    if (q_count_q < PTR_W'(n_out)) n_out = q_count_q[1:0];
    if (headroom < FLC_W'(n_out)) n_out = headroom[1:0];
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_out) begin
        wr_en_c[k]  = 1'b1;
        wr_tag_c[k] = mem_q[QA_W'(rd_ptr_q[QA_W-1:0] + QA_W'(k))];
      end
    end
  end

  // Enqueue: compact valid non-zero tags in slot order; drop the whole cycle on overflow
  always_comb begin
    n_in  = '0;
    ovf_d = ovf_q;
    for (int k = 0; k < 3; k++) enq_tag[k] = '0;
`ifdef RELEASE_DUP_CHECK_EN
    dup_d = dup_q;
    seen  = '0;
`endif
    if ((|slot_valid) && !rel_ready) begin
      ovf_d = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (slot_valid[k] && (slot_tag[k] != '0)) begin
`ifdef RELEASE_DUP_CHECK_EN
          if (pend_q[slot_tag[k]] || seen[slot_tag[k]]) begin
            dup_d = 1'b1;
          end else begin
            seen[slot_tag[k]] = 1'b1;
            enq_tag[n_in]     = slot_tag[k];
            n_in              = n_in + 2'd1;
          end
`else
          enq_tag[n_in] = slot_tag[k];
          n_in          = n_in + 2'd1;
`endif
        end
      end
    end
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_in) mem_d[QA_W'(wr_ptr_q[QA_W-1:0] + QA_W'(k))] = enq_tag[k];
    end
    wr_ptr_d  = wr_ptr_q + PTR_W'(n_in);
    rd_ptr_d  = rd_ptr_q + PTR_W'(n_out);
    q_count_d = q_count_q + PTR_W'(n_in) - PTR_W'(n_out);
`ifdef RELEASE_DUP_CHECK_EN
    pend_d = pend_q;
    for (int k = 0; k < 3; k++) begin
      if (wr_en_c[k]) pend_d[wr_tag_c[k]] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < n_in) pend_d[enq_tag[k]] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_count_q <= '0;
      ovf_q     <= 1'b0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
`ifdef RELEASE_DUP_CHECK_EN
      pend_q    <= '0;
      dup_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      q_count_q <= q_count_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
`ifdef RELEASE_DUP_CHECK_EN
      pend_q    <= pend_d;
      dup_q     <= dup_d;
`endif
    end
  end

  assign fl_wr_en_0  = wr_en_c[0];
  assign fl_wr_en_1  = wr_en_c[1];
  assign fl_wr_en_2  = wr_en_c[2];
  assign fl_wr_tag_0 = wr_tag_c[0];
  assign fl_wr_tag_1 = wr_tag_c[1];
  assign fl_wr_tag_2 = wr_tag_c[2];
  assign q_count     = q_count_q;
  assign ovf_err     = ovf_q;
`ifdef RELEASE_DUP_CHECK_EN
  assign dup_err     = dup_q;
`else
  assign dup_err     = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Bench for phys_reg_release_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_phys_reg_release_queue;

  localparam int FL_DEPTH = 32;
  localparam int TAG_W    = 5;
  localparam int Q_DEPTH  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rel_valid_0 = 1'b0, rel_valid_1 = 1'b0, rel_valid_2 = 1'b0;
  logic [TAG_W-1:0] rel_tag_0 = '0, rel_tag_1 = '0, rel_tag_2 = '0;
  logic             rel_ready;
  logic [TAG_W:0]   fl_count = '0;
  logic             fl_wr_en_0, fl_wr_en_1, fl_wr_en_2;
  logic [TAG_W-1:0] fl_wr_tag_0, fl_wr_tag_1, fl_wr_tag_2;
  logic [3:0]       q_count;
  logic             ovf_err, dup_err;

  phys_reg_release_queue dut (
    .clk(clk), .rst_n(rst_n),
    .rel_valid_0(rel_valid_0), .rel_valid_1(rel_valid_1), .rel_valid_2(rel_valid_2),
    .rel_tag_0(rel_tag_0), .rel_tag_1(rel_tag_1), .rel_tag_2(rel_tag_2),
    .rel_ready(rel_ready), .fl_count(fl_count),
    .fl_wr_en_0(fl_wr_en_0), .fl_wr_en_1(fl_wr_en_1), .fl_wr_en_2(fl_wr_en_2),
    .fl_wr_tag_0(fl_wr_tag_0), .fl_wr_tag_1(fl_wr_tag_1), .fl_wr_tag_2(fl_wr_tag_2),
    .q_count(q_count), .ovf_err(ovf_err), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mq[$];
  bit   ovf_m = 1'b0;
  bit   dup_m = 1'b0;
  logic [2:0]  obs_en;
  logic [31:0] obs_tag [3];
  logic [31:0] obs_q;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model at negedge, advance the model
  task automatic step(input logic [2:0] v, input int t0, input int t1, input int t2, input int flc);
    int t[3];
    int acc[$];
    int qs, hr, nout, e;
    bit rdy, hit;
    t = '{t0, t1, t2};
    rel_valid_0 = v[0]; rel_valid_1 = v[1]; rel_valid_2 = v[2];
    rel_tag_0 = TAG_W'(t0); rel_tag_1 = TAG_W'(t1); rel_tag_2 = TAG_W'(t2);
    fl_count = (TAG_W+1)'(flc);
    @(negedge clk);
    qs   = mq.size();
    rdy  = (Q_DEPTH - qs) >= 3;
    hr   = (flc >= FL_DEPTH) ? 0 : FL_DEPTH - flc;
    nout = (qs > 3) ? 3 : qs;
    if (hr < nout) nout = hr;
    obs_en     = {fl_wr_en_2, fl_wr_en_1, fl_wr_en_0};
    obs_tag[0] = 32'(fl_wr_tag_0);
    obs_tag[1] = 32'(fl_wr_tag_1);
    obs_tag[2] = 32'(fl_wr_tag_2);
    obs_q      = 32'(q_count);
    chk("q_count", obs_q, 32'(qs));
    chk("rel_ready", 32'(rel_ready), 32'(rdy));
    chk("ovf_err", 32'(ovf_err), 32'(ovf_m));
    chk("dup_err", 32'(dup_err), 32'(dup_m));
    for (int k = 0; k < 3; k++) begin
      e = (k < nout) ? mq[k] : 0;
      chk($sformatf("fl_wr_en_%0d", k), 32'(obs_en[k]), 32'(k < nout));
      chk($sformatf("fl_wr_tag_%0d", k), obs_tag[k], 32'(e));
    end
    if (|v) begin
      if (!rdy) ovf_m = 1'b1;
      else begin
        for (int k = 0; k < 3; k++) begin
          if (v[k] && t[k] != 0) begin
            hit = 1'b0;
`ifdef RELEASE_DUP_CHECK_EN
            foreach (mq[i]) if (mq[i] == t[k]) hit = 1'b1;
            foreach (acc[i]) if (acc[i] == t[k]) hit = 1'b1;
`endif
            if (hit) dup_m = 1'b1;
            else acc.push_back(t[k]);
          end
        end
      end
    end
    repeat (nout) void'(mq.pop_front());
    foreach (acc[i]) mq.push_back(acc[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rel_valid_0 = 1'b0; rel_valid_1 = 1'b0; rel_valid_2 = 1'b0;
    rel_tag_0 = '0; rel_tag_1 = '0; rel_tag_2 = '0;
    fl_count = '0;
    rst_n = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
    dup_m = 1'b0;
    @(negedge clk);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_rel_ready", 32'(rel_ready), 32'd1);
    chk("rst_fl_wr_en", 32'({fl_wr_en_2, fl_wr_en_1, fl_wr_en_0}), 32'd0);
    chk("rst_fl_wr_tag0", 32'(fl_wr_tag_0), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    chk("rst_dup_err", 32'(dup_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    step(3'b000, 0, 0, 0, 20);

    // 5,6,7 released together, drained next cycle
    step(3'b111, 5, 6, 7, 20);
    step(3'b000, 0, 0, 0, 20);
    chk("burst_en", 32'(obs_en), 32'b111);
    chk("burst_tag0", obs_tag[0], 32'd5);
    chk("burst_tag2", obs_tag[2], 32'd7);
    step(3'b000, 0, 0, 0, 20);
    chk("burst_empty", obs_q, 32'd0);

    // sparse slots and tag 0 filtering
    step(3'b010, 0, 9, 0, 20);
    step(3'b101, 3, 0, 0, 20);
    chk("sparse_9", obs_tag[0], 32'd9);
    chk("sparse_en9", 32'(obs_en), 32'b001);
    step(3'b000, 0, 0, 0, 20);
    chk("sparse_3", obs_tag[0], 32'd3);
    chk("sparse_peak", obs_q, 32'd1);
    step(3'b000, 0, 0, 0, 20);

    // headroom limiting
    step(3'b111, 4, 8, 12, 31);
    step(3'b000, 0, 0, 0, 31);
    chk("hr1_en", 32'(obs_en), 32'b001);
    chk("hr1_tag", obs_tag[0], 32'd4);
    step(3'b000, 0, 0, 0, 32);
    chk("hr0_en", 32'(obs_en), 32'b000);
    step(3'b000, 0, 0, 0, 29);
    chk("hr3_en", 32'(obs_en), 32'b011);
    chk("hr3_tag1", obs_tag[1], 32'd12);
    step(3'b000, 0, 0, 0, 29);

    // fill to backpressure, overflow, then wrap-around drain
    step(3'b111, 1, 2, 3, 32);
    step(3'b111, 13, 14, 15, 32);
    step(3'b111, 16, 17, 18, 32);
    chk("full_ready", 32'(rel_ready), 32'd0);
    step(3'b000, 0, 0, 0, 32);
    chk("ovf_q", obs_q, 32'd6);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    step(3'b000, 0, 0, 0, 0);
    chk("wrap_tag0", obs_tag[0], 32'd1);
    step(3'b000, 0, 0, 0, 0);
    chk("wrap_tag2", obs_tag[2], 32'd15);
    step(3'b000, 0, 0, 0, 0);
    chk("wrap_empty", 32'(obs_en), 32'b000);

`ifdef RELEASE_DUP_CHECK_EN
    do_reset();
    step(3'b001, 11, 0, 0, 32);
    step(3'b001, 11, 0, 0, 32);
    step(3'b000, 0, 0, 0, 0);
    chk("dup_one_write", 32'(obs_en), 32'b001);
    chk("dup_tag", obs_tag[0], 32'd11);
    step(3'b000, 0, 0, 0, 0);
    chk("dup_no_second", 32'(obs_en), 32'b000);
    chk("dup_flag", 32'(dup_err), 32'd1);
`endif

    // random traffic with a mid-run reset
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      step(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(22, 32)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
